// File: rtl/enc_pkg.sv
// Shared sizes and state encoding for the 16-to-4 scanning encoder.
package enc_pkg;

    localparam int N_IN  = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        EMPTY = 2'd2
    } state_e;

endpackage

// File: rtl/lsb_find16.sv
// Combinational lowest-set-bit finder over an ascending 16-bit vector.
// Index 0 is the lowest index. idx is numeric, with idx[0] as its MSB.
module lsb_find16
    import enc_pkg::*;
(
    input  logic [0:N_IN-1]  vec,
    output logic [0:IDX_W-1] idx,
    output logic             any,
    output logic             single
);

    // Priority scan from the top down so that the lowest set index wins.
    always_comb begin
        idx    = '0;
        any    = |vec;
        single = ($countones(vec) == 1);
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/encoder16x4_scan.sv
// Sequential 16-to-4 encoder. It emits the index of every set bit of an
// accepted word, lowest first, with one beat per cycle.
//
// state | meaning
// IDLE  | no word held; accepting when en=1
// SCAN  | pending holds the unsent bits; beat = lowest pending index
// EMPTY | presenting the single beat for an all-zero word
module encoder16x4_scan
    import enc_pkg::*;
#(
    parameter bit EMPTY_BEAT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:N_IN-1]  in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:IDX_W-1] out,
    output logic             out_last,
    output logic             out_none
);

    state_e            state_q, state_d;
    logic [0:N_IN-1]   pending_q, pending_d;
    logic [0:IDX_W-1]  low_idx;
    logic              pend_any;
    logic              pend_single;

    lsb_find16 u_find (
        .vec    (pending_q),
        .idx    (low_idx),
        .any    (pend_any),
        .single (pend_single)
    );

    // Beat outputs decode only from registered state and pending bits.
    // The empty marker is the EMPTY state itself, so no separate flag register is kept.
    always_comb begin
        out_valid = 1'b0;
        out       = '0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        case (state_q)
            SCAN: begin
                out_valid = pend_any;
                out       = low_idx;
                out_last  = pend_single;
            end
            EMPTY: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_none  = 1'b1;
            end
            default: ;
        endcase
    end

    // Ready is the only path from an input to an output. A last-beat handshake lets the next word in with no bubble.
    always_comb begin
        in_ready = en && ((state_q == IDLE) || (out_valid && out_last && out_ready));
    end

    // Next-state logic: retire the current beat first, then any accepted word overrides state and pending.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            SCAN: begin
                if (out_ready) begin
                    pending_d[low_idx] = 1'b0;
                    if (pend_single) begin
                        state_d = IDLE;
                    end
                end
            end
            EMPTY: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
        if (in_valid && in_ready) begin
            if (in != '0) begin
                pending_d = in;
                state_d   = SCAN;
            end else if (EMPTY_BEAT) begin
                state_d   = EMPTY;
            end else begin
                state_d   = IDLE;
            end
        end
    end

    // State and pending registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_encoder16x4_scan.sv
// Bench for encoder16x4_scan. A queue-of-beats reference model checks
// directed and random traffic on both EMPTY_BEAT settings.
module tb_encoder16x4_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        iv1 = 1'b0, iv0 = 1'b0;
    logic [0:15] in_s = '0;
    logic        out_ready = 1'b0;
    logic        sel = 1'b1;

    logic        ir1, ov1, ol1, on1;
    logic [0:3]  o1;
    logic        ir0, ov0, ol0, on0;
    logic [0:3]  o0;

    logic        ir, ov, ol, on_;
    logic [0:3]  o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] idx;
        logic       last;
        logic       none;
    } beat_t;
    beat_t q[$];

    encoder16x4_scan #(.EMPTY_BEAT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(iv1), .in_ready(ir1),
        .in(in_s), .out_valid(ov1), .out_ready(out_ready), .out(o1),
        .out_last(ol1), .out_none(on1)
    );

    encoder16x4_scan #(.EMPTY_BEAT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(iv0), .in_ready(ir0),
        .in(in_s), .out_valid(ov0), .out_ready(out_ready), .out(o0),
        .out_last(ol0), .out_none(on0)
    );

    assign ir  = sel ? ir1 : ir0;
    assign ov  = sel ? ov1 : ov0;
    assign ol  = sel ? ol1 : ol0;
    assign on_ = sel ? on1 : on0;
    assign o   = sel ? o1  : o0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive the inputs, compare the DUT with the model, then advance the model on the edge.
    task automatic cyc(input logic v, input logic [0:15] w, input logic rdy, input logic e);
        logic exp_rdy;
        logic exp_valid;
        int   last_i;
        @(negedge clk);
        en = e; in_s = w; out_ready = rdy;
        iv1 = sel ? v : 1'b0;
        iv0 = sel ? 1'b0 : v;
        #1;
        exp_valid = (q.size() != 0);
        exp_rdy   = e && (q.size() == 0 || (q.size() == 1 && rdy));
        check("out_valid", 32'(ov), 32'(exp_valid));
        check("in_ready", 32'(ir), 32'(exp_rdy));
        if (exp_valid) begin
            check("beat", {26'd0, o, ol, on_}, {26'd0, q[0].idx, q[0].last, q[0].none});
        end
        @(posedge clk);
        if (exp_valid && rdy) void'(q.pop_front());
        if (v && exp_rdy) begin
            if (w == '0) begin
                if (sel) q.push_back('{idx: 4'd0, last: 1'b1, none: 1'b1});
            end else begin
                last_i = 0;
                for (int i = 0; i < 16; i++) if (w[i]) last_i = i;
                for (int i = 0; i < 16; i++)
                    if (w[i]) q.push_back('{idx: 4'(i), last: (i == last_i), none: 1'b0});
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b1);
    endtask

    task automatic random_phase(input int n);
        logic [0:15] w;
        int pick;
        for (int i = 0; i < n; i++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0)      w = 16'h0000;
            else if (pick == 1) w = 16'hFFFF;
            else if (pick < 5)  w = 16'($urandom) & 16'($urandom) & 16'($urandom);
            else                w = 16'($urandom);
            cyc(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 4) != 0));
        end
    endtask

    initial begin
        logic [15:0] dec;
        logic [15:0] one;
        sel = 1'b1;
        #12 rst_n = 1'b1;

        // Reset mid-word: outputs drop without waiting for a clock.
        cyc(1'b1, 16'h8421, 1'b0, 1'b1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(ov1), 32'd0);
        check("rst_out", 32'(o1), 32'd0);
        check("rst_out_last", 32'(ol1), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;
        #1 check("rst_in_ready", 32'(ir1), 32'd1);

        // Single bit 5.
        cyc(1'b1, 16'h0400, 1'b1, 1'b1);
        #1;
        check("single_out", 32'(o1), 32'd5);
        check("single_last", 32'(ol1), 32'd1);
        check("single_ready", 32'(ir1), 32'd1);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1);

        // Back-to-back: {0,3,15} then {7} with no gap.
        cyc(1'b1, 16'h9001, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0100, 1'b1, 1'b1);
        #1 check("b2b_seventh", 32'(o1), 32'd7);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1);

        // Backpressure on {2,9}.
        cyc(1'b1, 16'h2040, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b1);
        #1 check("bp_hold", 32'(o1), 32'd2);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1);
        #1 check("bp_nine_last", {28'd0, o1}, {28'd9});
        cyc(1'b0, 16'h0000, 1'b1, 1'b1);

        // Bit 15 only, then an empty word.
        cyc(1'b1, 16'h0001, 1'b1, 1'b1);
        #1 check("bit15", {26'd0, o1, ol1, ov1}, {26'd0, 4'b1111, 1'b1, 1'b1});
        cyc(1'b1, 16'h0000, 1'b1, 1'b1);
        #1 check("empty_beat", {28'd0, ov1, o1 == 4'd0, on1, ol1}, 32'hF);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1);

        // Full word.
        cyc(1'b1, 16'hFFFF, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b1);

        // en low mid-word: the word completes, no new word is taken.
        cyc(1'b1, 16'h1110, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0002, 1'b1, 1'b0);
        #1 check("en_block", {30'd0, ov1, ir1}, 32'd0);
        cyc(1'b1, 16'h0002, 1'b1, 1'b1);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1);

        // Round trip through a decoder model for every one-hot word.
        for (int b = 0; b < 16; b++) begin
            one = 16'h8000 >> b;
            cyc(1'b1, one, 1'b1, 1'b1);
            #1;
            dec = 16'h8000 >> o1;
            check("roundtrip", 32'(dec), 32'(one));
        end
        drain();

        random_phase(400);
        drain();

        // EMPTY_BEAT=0 instance.
        sel = 1'b0;
        cyc(1'b1, 16'h0000, 1'b1, 1'b1);
        #1 check("silent_empty", {30'd0, ov0, ir0}, 32'd1);
        cyc(1'b1, 16'h0000, 1'b1, 1'b1);
        cyc(1'b1, 16'h4800, 1'b1, 1'b1);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1);
        random_phase(300);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
